// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and small decode helpers used by the unit and its divider core.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    function automatic logic is_mul_op(input md_op_e op_v);
        return (op_v == MD_MULT) || (op_v == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input md_op_e op_v);
        return (op_v == MD_DIV) || (op_v == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op_v);
        return (op_v == MD_MULT) || (op_v == MD_DIV);
    endfunction

    // States in which an operation is still in flight (results not yet committed)
    function automatic logic is_busy_state(input md_state_e st_v);
        return (st_v == ST_MUL) || (st_v == ST_DIV) || (st_v == ST_FIX);
    endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken on the load edge so the full quotient is ready WIDTH-1 cycles later.
module div_core
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;

    // One restoring step: shift the next dividend bit in, subtract if it fits
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem_v,
                                                     input logic [WIDTH-1:0] quo_v,
                                                     input logic [WIDTH-1:0] dvs_v);
        logic [WIDTH:0] trial_v;
        trial_v = {rem_v, quo_v[WIDTH-1]} - {1'b0, dvs_v};
        if (trial_v[WIDTH]) begin
            return {rem_v[WIDTH-2:0], quo_v[WIDTH-1], quo_v[WIDTH-2:0], 1'b0};
        end else begin
            return {trial_v[WIDTH-1:0], quo_v[WIDTH-2:0], 1'b1};
        end
    endfunction

    // Load operands (taking the first step) or iterate until the count runs out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
        end else if (load) begin
            {rem_r, quo_r} <= div_step({WIDTH{1'b0}}, dividend, divisor);
            dvs_r          <= divisor;
            cnt_r          <= CNT_W'(WIDTH - 1);
            ready_r        <= 1'b0;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
            cnt_r          <= cnt_r - CNT_W'(1);
            ready_r        <= (cnt_r == CNT_W'(1));
        end else begin
            ready_r <= ready_r;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign ready     = ready_r;

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage. Multiplies are a
// registered product plus a latency counter; divides run through div_core on
// magnitudes and get their signs restored in a final FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

    md_state_e        state_r, state_nxt_s;
    md_op_e           op_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2*WIDTH-1:0] prod_r, prod_s, a_ext_s, b_ext_s;
    logic [WIDTH-1:0] hi_r, lo_r, hi_nxt_s, lo_nxt_s;
    logic [WIDTH-1:0] a_abs_s, b_abs_s, quo_s, rem_s;
    logic             dz_r, dz_nxt_s, done_r, busy_r;
    logic             neg_q_r, neg_r_r;
    logic             accept_s, is_signed_s, b_zero_s, div_load_s, div_ready_s;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign op_s        = md_op_e'(op);
    assign accept_s    = start & ~flush & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign is_signed_s = is_signed_op(op_s);
    assign b_zero_s    = (b == {WIDTH{1'b0}});
    assign a_abs_s     = negate_if(a, is_signed_s & a[WIDTH-1]);
    assign b_abs_s     = negate_if(b, is_signed_s & b[WIDTH-1]);
    assign div_load_s  = accept_s & is_div_op(op_s) & ~b_zero_s;
    assign a_ext_s     = {{WIDTH{is_signed_s & a[WIDTH-1]}}, a};
    assign b_ext_s     = {{WIDTH{is_signed_s & b[WIDTH-1]}}, b};
    assign prod_s      = a_ext_s * b_ext_s;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load_s),
        .dividend  (a_abs_s),
        .divisor   (b_abs_s),
        .quotient  (quo_s),
        .remainder (rem_s),
        .ready     (div_ready_s)
    );

    // Next state, latency counter and the HI/LO/div_zero values to commit
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        dz_nxt_s    = dz_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                state_nxt_s = ST_IDLE;
                if (accept_s) begin
                    dz_nxt_s = 1'b0;
                    case (op_s)
                        MD_MULT, MD_MULTU: begin
                            if (MUL_CYCLES == 1) begin
                                state_nxt_s          = ST_DONE;
                                {hi_nxt_s, lo_nxt_s} = prod_s;
                            end else begin
                                state_nxt_s = ST_MUL;
                                cnt_nxt_s   = MUL_LOAD;
                            end
                        end
                        MD_DIV, MD_DIVU: begin
                            if (b_zero_s) begin
                                state_nxt_s = ST_DONE;
                                hi_nxt_s    = a;
                                lo_nxt_s    = {WIDTH{1'b1}};
                                dz_nxt_s    = 1'b1;
                            end else begin
                                state_nxt_s = ST_DIV;
                                cnt_nxt_s   = DIV_LOAD;
                            end
                        end
                        MD_MTHI: hi_nxt_s = a;
                        MD_MTLO: lo_nxt_s = a;
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s          = ST_DONE;
                    {hi_nxt_s, lo_nxt_s} = prod_r;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_FIX;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (div_ready_s) begin
                    state_nxt_s = ST_DONE;
                    hi_nxt_s    = negate_if(rem_s, neg_r_r);
                    lo_nxt_s    = negate_if(quo_s, neg_q_r);
                end else begin
                    state_nxt_s = ST_FIX;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, committed results, status flags and latched operand information
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            dz_r    <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            prod_r  <= {(2*WIDTH){1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            dz_r    <= dz_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            busy_r  <= is_busy_state(state_nxt_s);
            if (accept_s && is_mul_op(op_s)) begin
                prod_r <= prod_s;
            end else begin
                prod_r <= prod_r;
            end
            if (div_load_s) begin
                neg_q_r <= is_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_r <= is_signed_s & a[WIDTH-1];
            end else begin
                neg_q_r <= neg_q_r;
                neg_r_r <= neg_r_r;
            end
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = dz_r;
    assign stall    = busy_r & (start | rd_req);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops compared
// against a plain-arithmetic model of HI/LO, div_zero and op latency.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W  = 32;
    localparam int MC = 4;

    logic          clk, rst, start, rd_req, flush;
    logic [2:0]    op;
    logic [W-1:0]  a, b, hi, lo;
    logic          busy, stall, done, div_zero;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  model_hi = '0;
    logic [W-1:0]  model_lo = '0;
    logic          model_dz = 1'b0;

    mult_div_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .rd_req(rd_req), .flush(flush), .hi(hi), .lo(lo), .busy(busy),
        .stall(stall), .done(done), .div_zero(div_zero)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op; lat=0 means no done pulse is expected
    task automatic model_op(input logic [2:0] op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                            output logic [W-1:0] eh, output logic [W-1:0] el,
                            output int lat, output logic edz);
        longint      sq, sr;
        logic [63:0] p;
        eh = model_hi; el = model_lo; lat = 0; edz = 1'b0;
        case (op_v)
            MD_MULT: begin
                sq = longint'($signed(av)) * longint'($signed(bv));
                p = sq; {eh, el} = p; lat = MC;
            end
            MD_MULTU: begin
                p = {32'd0, av} * {32'd0, bv}; {eh, el} = p; lat = MC;
            end
            MD_DIV, MD_DIVU: begin
                if (bv == 32'd0) begin
                    eh = av; el = 32'hFFFF_FFFF; edz = 1'b1; lat = 1;
                end else if (op_v == MD_DIV) begin
                    sq = longint'($signed(av)) / longint'($signed(bv));
                    sr = longint'($signed(av)) % longint'($signed(bv));
                    p = sq; el = p[31:0];
                    p = sr; eh = p[31:0];
                    lat = W + 1;
                end else begin
                    el = av / bv; eh = av % bv; lat = W + 1;
                end
            end
            MD_MTHI: eh = av;
            MD_MTLO: el = av;
            default: lat = 0;
        endcase
    endtask

    // Issue one op from idle and check timing, stall behaviour and results
    task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] eh, el;
        logic         edz;
        int           lat, cyc, errs;
        model_op(op_v, av, bv, eh, el, lat, edz);
        start = 1'b1; op = op_v; a = av; b = bv;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        model_hi = eh; model_lo = el; model_dz = edz;
        if (lat == 0) begin
            check_value("mt_hi", hi, model_hi);
            check_value("mt_lo", lo, model_lo);
            check_value("mt_busy", busy, 0);
            check_value("mt_done", done, 0);
        end else begin
            check_value("dz_after_start", div_zero, edz);
            cyc = 1; errs = 0;
            while (done !== 1'b1 && cyc < 100) begin
                rd_req = 1'($urandom_range(0, 1));
                #1;
                if (busy !== 1'b1 || stall !== rd_req) errs++;
                rd_req = 1'b0;
                tick();
                cyc++;
            end
            check_value("latency", cyc, lat);
            check_value("busy_stall", errs, 0);
            check_value("hi", hi, model_hi);
            check_value("lo", lo, model_lo);
            check_value("div_zero", div_zero, model_dz);
            check_value("busy_at_done", busy, 0);
            rd_req = 1'b1; #1;
            check_value("stall_at_done", stall, 0);
            rd_req = 1'b0;
            tick();
            check_value("done_pulse", done, 0);
        end
    endtask

    // DIV with rd_req and a pending MULTU held on start; MULTU accepted on done cycle
    task automatic back_to_back();
        logic [W-1:0] eh1, el1, eh2, el2;
        logic         edz;
        int           lat1, lat2, cyc, errs;
        model_op(MD_DIV, 32'hFFFF_FF9C, 32'd7, eh1, el1, lat1, edz);
        start = 1'b1; op = MD_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
        tick();
        model_hi = eh1; model_lo = el1; model_dz = 1'b0;
        model_op(MD_MULTU, 32'h1234_5678, 32'h0000_0009, eh2, el2, lat2, edz);
        op = MD_MULTU; a = 32'h1234_5678; b = 32'h0000_0009; rd_req = 1'b1;
        cyc = 1; errs = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall !== 1'b1 || busy !== 1'b1) errs++;
            tick();
            cyc++;
        end
        check_value("b2b_lat1", cyc, lat1);
        check_value("b2b_stall", errs, 0);
        check_value("b2b_hi1", hi, eh1);
        check_value("b2b_lo1", lo, el1);
        tick();
        start = 1'b0; rd_req = 1'b0; a = $urandom; b = $urandom;
        model_hi = eh2; model_lo = el2;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check_value("b2b_lat2", cyc, lat2);
        check_value("b2b_hi2", hi, eh2);
        check_value("b2b_lo2", lo, el2);
        tick();
    endtask

    initial begin
        int           dones;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        rst = 1'b0; start = 1'b0; rd_req = 1'b0; flush = 1'b0;
        op = 3'd0; a = '0; b = '0;
        tick(); tick();
        check_value("rst_hi", hi, 0);
        check_value("rst_lo", lo, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_dz", div_zero, 0);
        rst = 1'b1;
        tick();

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        check_value("t1_hi", hi, 32'hFFFF_FFFF);
        check_value("t1_lo", lo, 32'hFFFF_FFEB);
        run_op(MD_DIVU, 32'd100, 32'd7);
        check_value("t2_lo", lo, 32'd14);
        check_value("t2_hi", hi, 32'd2);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check_value("t2s_lo", lo, 32'hFFFF_FFFD);
        check_value("t2s_hi", hi, 32'hFFFF_FFFF);
        run_op(MD_DIV, 32'd5, 32'd0);
        check_value("t3_dz", div_zero, 1);
        run_op(MD_MULTU, 32'd3, 32'd4);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_value("minneg_lo", lo, 32'h8000_0000);
        check_value("minneg_hi", hi, 32'd0);

        back_to_back();

        // Flush two cycles into a multiply: no done, HI/LO untouched
        start = 1'b1; op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0; model_dz = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_value("flush_busy", busy, 0);
        dones = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check_value("flush_no_done", dones, 0);
        check_value("flush_hi", hi, model_hi);
        check_value("flush_lo", lo, model_lo);

        // Flush coincident with start discards the start
        start = 1'b1; flush = 1'b1; op = MD_MULT; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        check_value("flush_start_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < MC + 2; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check_value("flush_start_no_done", dones, 0);
        check_value("flush_start_lo", lo, model_lo);

        // Asynchronous reset in the middle of a divide
        start = 1'b1; op = MD_DIV; a = 32'd12345; b = 32'd17;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        check_value("midrst_hi", hi, 0);
        check_value("midrst_lo", lo, 0);
        check_value("midrst_busy", busy, 0);
        model_hi = '0; model_lo = '0; model_dz = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_op(MD_MTHI, 32'h0000_1234, 32'd0);
        run_op(MD_MTLO, 32'h0000_5678, 32'd0);
        check_value("mt_hi_val", hi, 32'h0000_1234);
        check_value("mt_lo_val", lo, 32'h0000_5678);

        // Random ops with biased corner operands
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 100));
                4: rb = -32'($urandom_range(1, 9));
                default: ra = ra;
            endcase
            run_op(rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
